std_linear_sec_encoder_pipe: RTL



---
 rtl/std_sec_pkg.sv | 63 ++++++
 rtl/std_pipe_stage.sv | 30 +++
 rtl/std_linear_sec_encoder_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/std_sec_pkg.sv
// Shared Hamming SEC layout for the std_linear_sec encoder/decoder pair.
// Positions are 1-indexed. Power-of-two positions carry even parity, and data
// bits fill the remaining positions in ascending order.
// The helper functions work on fixed maximum widths (P up to SEC_MAX_P), so one
// definition serves every parameterisation of the two blocks.
package std_sec_pkg;

  localparam int P_DEFAULT = 4;
  localparam int K_DEFAULT = (1 << P_DEFAULT) - 1;

  localparam int SEC_MAX_P = 6;
  localparam int SEC_MAX_K = (1 << SEC_MAX_P) - 1;
  localparam int SEC_MAX_N = SEC_MAX_K - SEC_MAX_P;

  function automatic logic sec_is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // 1-indexed codeword position of data bit j (0 if j is out of range)
  function automatic int sec_data_pos(input int j);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 1; pos <= SEC_MAX_K; pos++) begin
      if (!sec_is_pow2(pos)) begin
        if ((cnt == j) && (res == 0)) res = pos;
        cnt++;
      end
    end
    return res;
  endfunction

  // Clean codeword for a p-parity-bit code; bits above (1<<p)-1 stay 0
  function automatic logic [SEC_MAX_K-1:0] sec_encode(input logic [SEC_MAX_N-1:0] word,
                                                      input int p);
    logic [SEC_MAX_K-1:0] cw;
    logic                 par;
    int                   k;
    int                   idx;
    k   = (1 << p) - 1;
    cw  = '0;
    idx = 0;
    for (int pos = 1; pos <= SEC_MAX_K; pos++) begin
      if ((pos <= k) && !sec_is_pow2(pos)) begin
        cw[pos-1] = word[idx];
        idx++;
      end
    end
    // parity slots are still 0 here, so including them in the XOR is harmless
    for (int b = 0; b < SEC_MAX_P; b++) begin
      if (b < p) begin
        par = 1'b0;
        for (int pos = 1; pos <= SEC_MAX_K; pos++) begin
          if ((pos <= k) && (((pos >> b) & 1) != 0)) par = par ^ cw[pos-1];
        end
        cw[(1 << b) - 1] = par;
      end
    end
    return cw;
  endfunction

endpackage

// File: rtl/std_pipe_stage.sv
// One-entry valid/ready register slice. It accepts whenever it is empty or its
// content leaves this cycle, giving full throughput with no bubble. up_ready
// is combinational from dn_ready.
module std_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  assign up_ready = !dn_valid || dn_ready;

  // load a new entry (or empty out) whenever the slot advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/std_linear_sec_encoder_pipe.sv
// Streaming Hamming SEC encoder with a two-stage valid/ready pipeline.
// S1 holds the raw word and any armed injection position. S2 holds the
// finished codeword.
// Optional error injection is enabled by defining STD_SEC_ENCODER_INJECT_EN.
// Without it the injection inputs are ignored, and pending/count read 0.
module std_linear_sec_encoder_pipe
  import std_sec_pkg::*;
#(
  parameter int P     = P_DEFAULT,
  parameter int K     = (1 << P) - 1,
  parameter int N     = K - P,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N-1:0]     i_word,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [K-1:0]     o_codeword,
  input  logic             i_inject_req,
  input  logic [P-1:0]     i_inject_pos,
  output logic             o_inject_pending,
  output logic [CNT_W-1:0] o_inject_count
);

`ifdef STD_SEC_ENCODER_INJECT_EN
  localparam int S1_W = N + P;
  localparam int S2_W = K + 1;
`else
  localparam int S1_W = N;
  localparam int S2_W = K;
`endif

  logic                 s1_valid;
  logic                 s1_ready;
  logic                 s2_ready;
  logic [S1_W-1:0]      s1_in;
  logic [S1_W-1:0]      s1_out;
  logic [S2_W-1:0]      s2_in;
  logic [S2_W-1:0]      s2_out;
  logic [N-1:0]         s1_word;
  logic [SEC_MAX_K-1:0] clean_full;
  logic                 unused_hi;

  assign s1_word    = s1_out[N-1:0];
  assign clean_full = sec_encode(SEC_MAX_N'(s1_word), P);
  assign unused_hi  = ^clean_full;

`ifdef STD_SEC_ENCODER_INJECT_EN
  logic             inj_pending;
  logic [P-1:0]     inj_pos;
  logic [CNT_W-1:0] inj_count;
  logic [P-1:0]     s1_pos;
  logic [K-1:0]     flip;
  logic             req_ok;
  logic             s1_take;
  logic             s2_inj;

  assign req_ok  = i_inject_req && (i_inject_pos != '0) && (int'(i_inject_pos) <= K);
  assign s1_take = i_valid && s1_ready;
  assign s1_pos  = s1_out[N+P-1:N];
  assign s2_inj  = s2_out[K];

  // a new request wins over consumption, so a same-cycle request arms the next word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inj_pending <= 1'b0;
      inj_pos     <= '0;
    end else if (req_ok) begin
      inj_pending <= 1'b1;
      inj_pos     <= i_inject_pos;
    end else if (s1_take) begin
      inj_pending <= 1'b0;
    end
  end

  assign s1_in = {(inj_pending ? inj_pos : {P{1'b0}}), i_word};

  // one-hot flip mask for the position carried by S1
  always_comb begin
    flip = '0;
    for (int i = 0; i < K; i++) flip[i] = (int'(s1_pos) == (i + 1));
  end

  assign s2_in = {(s1_pos != '0), clean_full[K-1:0] ^ flip};

  // count injected codewords as they leave, saturating at all-ones
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inj_count <= '0;
    end else if (o_valid && i_ready && s2_inj && (inj_count != '1)) begin
      inj_count <= inj_count + 1'b1;
    end
  end

  assign o_inject_pending = inj_pending;
  assign o_inject_count   = inj_count;
`else
  logic unused_inject;

  assign unused_inject    = ^{i_inject_req, i_inject_pos};
  assign s1_in            = i_word;
  assign s2_in            = clean_full[K-1:0];
  assign o_inject_pending = 1'b0;
  assign o_inject_count   = '0;
`endif

  std_pipe_stage #(.W(S1_W)) u_s1 (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .up_valid (i_valid),
    .up_ready (s1_ready),
    .up_data  (s1_in),
    .dn_valid (s1_valid),
    .dn_ready (s2_ready),
    .dn_data  (s1_out)
  );

  std_pipe_stage #(.W(S2_W)) u_s2 (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .up_valid (s1_valid),
    .up_ready (s2_ready),
    .up_data  (s2_in),
    .dn_valid (o_valid),
    .dn_ready (i_ready),
    .dn_data  (s2_out)
  );

  assign o_ready    = s1_ready;
  assign o_codeword = s2_out[K-1:0];

endmodule
